upc_loop_monitor: RTL and testbench

Synthesizable performance monitor for one HLS-generated block and one of its pipelined loops. It watches the block-level handshake (ap_start/ap_ready/ap_done/ap_continue) and the loop FSM (state, stage block, pipeline enables, loop handshake). It accumulates transaction, iteration, stall and latency counters. It sits beside the design under observation, fed by hierarchical taps, and is read out after `finish`.

---
 rtl/upc_loop_monitor.sv | 172 +++++++++++++++++
 tb/tb_upc_loop_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upc_loop_monitor.sv
// upc_loop_monitor
//   Performance monitor for an HLS block and one of its pipelined loops.
//   It is fed by taps on the block handshake and the loop FSM, and it keeps
//   saturating counters for transactions, iterations, stalls and loop latency.
//   Once finish is seen, the monitor freezes until reset.
//
// Ports
//   clock, reset (async, active-low), finish (sticky freeze request)
//   mod_start/mod_ready/mod_done/mod_continue      block handshake taps
//   cur_state, iter_start_state, iter_end_state, quit_state
//                                                  observed FSM state and reference states
//   iter_*/quit_* block and enable                 stage subdone flags and pipeline enables
//   loop_start/loop_ready/loop_done/loop_continue  loop handshake taps
//   quit_at_end                                    select loop_done or the quit event as close
//   mod_started, mod_completed, mod_busy_cycles, mod_active
//   loop_invocations, iters_started, iters_ended, loop_stall_cycles,
//   last_loop_latency, loop_active, frozen
module upc_loop_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               mod_start,
    input  logic               mod_ready,
    input  logic               mod_done,
    input  logic               mod_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic [CNT_W-1:0]   mod_started,
    output logic [CNT_W-1:0]   mod_completed,
    output logic [CNT_W-1:0]   mod_busy_cycles,
    output logic               mod_active,
    output logic [CNT_W-1:0]   loop_invocations,
    output logic [CNT_W-1:0]   iters_started,
    output logic [CNT_W-1:0]   iters_ended,
    output logic [CNT_W-1:0]   loop_stall_cycles,
    output logic [CNT_W-1:0]   last_loop_latency,
    output logic               loop_active,
    output logic               frozen
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } loop_state_t;

    loop_state_t      state;
    loop_state_t      state_nxt;
    logic [7:0]       outstanding;
    logic [CNT_W-1:0] latency_acc;

    logic mstart, mdone, istart, iend, quit, stall, close_ev;
    logic count_en;
    logic open_inv, close_inv;

    // loop_ready is tapped for completeness; no event depends on it.
    logic unused_taps;
    assign unused_taps = loop_ready;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Events decoded from the sampled taps.
    assign mstart   = mod_start & mod_ready;
    assign mdone    = mod_done & mod_continue;
    assign istart   = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign iend     = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign quit     = (cur_state == quit_state) & quit_enable & ~quit_block;
    assign stall    = (cur_state == iter_start_state) & iter_start_enable & iter_start_block;
    assign close_ev = quit_at_end ? (loop_done & loop_continue) : quit;

    // The edge that samples finish is already frozen: its events are dropped.
    assign count_en = ~frozen & ~finish;

    assign mod_active  = (outstanding != 8'd0);
    assign loop_active = (state == RUN);

    // Loop FSM next-state. A close together with a new start hands the loop
    // straight over to the next invocation without passing through IDLE.
    always_comb begin
        state_nxt = state;
        open_inv  = 1'b0;
        close_inv = 1'b0;
        case (state)
            IDLE: begin
                if (loop_start) begin
                    state_nxt = RUN;
                    open_inv  = 1'b1;
                end
            end
            RUN: begin
                if (close_ev) begin
                    close_inv = 1'b1;
                    if (loop_start) begin
                        open_inv = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            frozen            <= 1'b0;
            outstanding       <= 8'd0;
            latency_acc       <= '0;
            mod_started       <= '0;
            mod_completed     <= '0;
            mod_busy_cycles   <= '0;
            loop_invocations  <= '0;
            iters_started     <= '0;
            iters_ended       <= '0;
            loop_stall_cycles <= '0;
            last_loop_latency <= '0;
        end else begin
            if (finish) begin
                frozen <= 1'b1;
            end
            if (count_en) begin
                state <= state_nxt;

                if (mstart) mod_started   <= sat_inc(mod_started);
                if (mdone)  mod_completed <= sat_inc(mod_completed);
                if (outstanding != 8'd0) mod_busy_cycles <= sat_inc(mod_busy_cycles);

                // A done with nothing outstanding is counted above but cannot
                // drive the outstanding count below zero.
                if (mstart && !mdone && outstanding != 8'hFF) begin
                    outstanding <= outstanding + 8'd1;
                end else if (mdone && !mstart && outstanding != 8'd0) begin
                    outstanding <= outstanding - 8'd1;
                end

                if (istart) iters_started <= sat_inc(iters_started);
                if (iend)   iters_ended   <= sat_inc(iters_ended);
                if (stall && state == RUN) loop_stall_cycles <= sat_inc(loop_stall_cycles);

                // The accumulator holds cycles seen so far; the close edge
                // itself is included, hence the +1 on capture.
                if (close_inv) last_loop_latency <= sat_inc(latency_acc);
                if (open_inv) begin
                    loop_invocations <= sat_inc(loop_invocations);
                    latency_acc      <= CNT_W'(1);
                end else if (state == RUN) begin
                    latency_acc <= sat_inc(latency_acc);
                end
            end
        end
    end

endmodule

// File: tb/tb_upc_loop_monitor.sv
module tb_upc_loop_monitor;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic clock, reset, finish;
    logic mod_start, mod_ready, mod_done, mod_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic iter_start_block, iter_end_block, quit_block;
    logic iter_start_enable, iter_end_enable, quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic [CNT_W-1:0] mod_started, mod_completed, mod_busy_cycles;
    logic [CNT_W-1:0] loop_invocations, iters_started, iters_ended, loop_stall_cycles, last_loop_latency;
    logic mod_active, loop_active, frozen;

    upc_loop_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done), .mod_continue(mod_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .quit_state(quit_state), .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .mod_started(mod_started), .mod_completed(mod_completed), .mod_busy_cycles(mod_busy_cycles),
        .mod_active(mod_active), .loop_invocations(loop_invocations), .iters_started(iters_started),
        .iters_ended(iters_ended), .loop_stall_cycles(loop_stall_cycles),
        .last_loop_latency(last_loop_latency), .loop_active(loop_active), .frozen(frozen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_started, m_completed, m_busy, m_out, m_inv, m_is, m_ie, m_stall, m_last, m_acc;
    bit m_running, m_frozen;

    function automatic int cap(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_started = 0; m_completed = 0; m_busy = 0; m_out = 0; m_inv = 0;
            m_is = 0; m_ie = 0; m_stall = 0; m_last = 0; m_acc = 0;
            m_running = 0; m_frozen = 0;
        end else if (!m_frozen) begin
            if (finish) begin
                m_frozen = 1;
            end else begin
                bit ms, md, is_ev, ie_ev, q_ev, st_ev, cl_ev;
                ms    = mod_start && mod_ready;
                md    = mod_done && mod_continue;
                is_ev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
                ie_ev = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
                q_ev  = (cur_state == quit_state) && quit_enable && !quit_block;
                st_ev = (cur_state == iter_start_state) && iter_start_enable && iter_start_block;
                cl_ev = quit_at_end ? (loop_done && loop_continue) : q_ev;
                if (ms) m_started = cap(m_started + 1, MAXC);
                if (md) m_completed = cap(m_completed + 1, MAXC);
                if (m_out > 0) m_busy = cap(m_busy + 1, MAXC);
                if (ms && !md) m_out = cap(m_out + 1, 255);
                else if (md && !ms && m_out > 0) m_out = m_out - 1;
                if (is_ev) m_is = cap(m_is + 1, MAXC);
                if (ie_ev) m_ie = cap(m_ie + 1, MAXC);
                if (m_running && st_ev) m_stall = cap(m_stall + 1, MAXC);
                if (m_running) begin
                    m_acc = cap(m_acc + 1, MAXC);   // cycles from start edge through this edge
                    if (cl_ev) begin
                        m_last = m_acc;
                        if (loop_start) begin
                            m_inv = cap(m_inv + 1, MAXC);
                            m_acc = 1;
                        end else begin
                            m_running = 0;
                        end
                    end
                end else if (loop_start) begin
                    m_running = 1;
                    m_inv = cap(m_inv + 1, MAXC);
                    m_acc = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (check_en) begin
            chk("mod_started", int'(mod_started), m_started);
            chk("mod_completed", int'(mod_completed), m_completed);
            chk("mod_busy_cycles", int'(mod_busy_cycles), m_busy);
            chk("mod_active", int'(mod_active), int'(m_out > 0));
            chk("loop_invocations", int'(loop_invocations), m_inv);
            chk("iters_started", int'(iters_started), m_is);
            chk("iters_ended", int'(iters_ended), m_ie);
            chk("loop_stall_cycles", int'(loop_stall_cycles), m_stall);
            chk("last_loop_latency", int'(last_loop_latency), m_last);
            chk("loop_active", int'(loop_active), int'(m_running));
            chk("frozen", int'(frozen), int'(m_frozen));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        finish = 0; mod_start = 0; mod_ready = 0; mod_done = 0; mod_continue = 0;
        cur_state = 0; iter_start_state = 2'd1; iter_end_state = 2'd2; quit_state = 2'd3;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs();
        mod_start = 1'($urandom); mod_ready = 1'($urandom);
        mod_done = 1'($urandom); mod_continue = 1'($urandom);
        cur_state = 2'($urandom); iter_start_state = 2'($urandom);
        iter_end_state = 2'($urandom); quit_state = 2'($urandom);
        iter_start_block = ($urandom_range(0, 3) == 0); iter_end_block = ($urandom_range(0, 3) == 0);
        quit_block = 1'($urandom);
        iter_start_enable = 1'($urandom); iter_end_enable = 1'($urandom); quit_enable = 1'($urandom);
        loop_start = ($urandom_range(0, 5) == 0); loop_ready = 1'($urandom);
        loop_done = ($urandom_range(0, 3) == 0); loop_continue = 1'($urandom);
        quit_at_end = 1'($urandom);
        finish = ($urandom_range(0, 399) == 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        repeat (2) step();
        reset = 1;
        step();
    endtask

    task automatic set_istart();
        cur_state = 2'd1; iter_start_enable = 1; iter_start_block = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1;
        clear_inputs();
        #1 reset = 0;
        check_en = 1;

        // Reset held: inputs toggle, nothing counts.
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            step();
        end
        chk("rst_mod_started", int'(mod_started), 0);
        chk("rst_iters_started", int'(iters_started), 0);
        chk("rst_loop_active", int'(loop_active), 0);
        clear_inputs();
        reset = 1;
        repeat (10) step();
        chk("idle_mod_busy", int'(mod_busy_cycles), 0);
        chk("idle_frozen", int'(frozen), 0);

        // Three block transactions, each done 5 cycles after start.
        for (int t = 0; t < 3; t++) begin
            mod_start = 1; mod_ready = 1;
            step();
            mod_start = 0; mod_ready = 0;
            repeat (4) step();
            mod_done = 1; mod_continue = 1;
            step();
            mod_done = 0; mod_continue = 0;
        end
        chk("hs_started", int'(mod_started), 3);
        chk("hs_completed", int'(mod_completed), 3);
        chk("hs_busy", int'(mod_busy_cycles), 15);
        chk("hs_active", int'(mod_active), 0);
        mod_start = 1; mod_ready = 1;
        step();
        mod_done = 1; mod_continue = 1;
        step();
        mod_start = 0; mod_ready = 0;
        chk("hs_same_cycle_active", int'(mod_active), 1);
        step();
        mod_done = 0; mod_continue = 0;
        chk("hs_drain_active", int'(mod_active), 0);

        // Loop of 8 iterations at II=1, closed by loop_done at cycle 34.
        do_reset();
        for (int c = 1; c <= 34; c++) begin
            clear_inputs();
            loop_start = (c == 1);
            if (c <= 8) set_istart();
            if (c >= 27) begin cur_state = 2'd2; iter_end_enable = 1; end
            loop_done = (c == 34); loop_continue = (c == 34);
            step();
            if (c == 20) chk("loop8_active_mid", int'(loop_active), 1);
        end
        clear_inputs();
        chk("loop8_started", int'(iters_started), 8);
        chk("loop8_ended", int'(iters_ended), 8);
        chk("loop8_inv", int'(loop_invocations), 1);
        chk("loop8_latency", int'(last_loop_latency), 34);
        chk("loop8_active", int'(loop_active), 0);

        // Stalls: one in IDLE (ignored), then four inside RUN.
        do_reset();
        cur_state = 2'd1; iter_start_enable = 1; iter_start_block = 1;
        step();
        clear_inputs();
        loop_start = 1;
        step();
        loop_start = 0;
        cur_state = 2'd1; iter_start_enable = 1; iter_start_block = 1;
        repeat (4) step();
        clear_inputs();
        chk("stall_cycles", int'(loop_stall_cycles), 4);
        chk("stall_iters", int'(iters_started), 0);

        // quit_at_end=0: the quit event at cycle 12 closes the invocation.
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            clear_inputs();
            quit_at_end = 0;
            loop_start = (c == 1);
            if (c == 12) begin cur_state = 2'd3; quit_enable = 1; end
            step();
        end
        clear_inputs();
        quit_at_end = 0;
        chk("quit_latency", int'(last_loop_latency), 12);
        chk("quit_active", int'(loop_active), 0);
        loop_done = 1; loop_continue = 1;
        step();
        loop_done = 0; loop_continue = 0;
        chk("quit_late_done_latency", int'(last_loop_latency), 12);
        chk("quit_late_done_inv", int'(loop_invocations), 1);

        // Random traffic with occasional asynchronous reset pulses.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 0;
                #3 reset = 1;
            end
            step();
        end

        // Saturation, then freeze.
        do_reset();
        mod_start = 1; mod_ready = 1;
        set_istart();
        repeat (300) step();
        chk("sat_started", int'(mod_started), MAXC);
        chk("sat_iters", int'(iters_started), MAXC);
        chk("sat_busy", int'(mod_busy_cycles), MAXC);
        finish = 1; mod_done = 1; mod_continue = 1; loop_start = 1;
        step();
        finish = 0;
        chk("frz_frozen", int'(frozen), 1);
        chk("frz_completed", int'(mod_completed), 0);
        repeat (5) step();
        clear_inputs();
        chk("frz_started", int'(mod_started), MAXC);
        chk("frz_completed_later", int'(mod_completed), 0);
        chk("frz_inv", int'(loop_invocations), 0);
        chk("frz_frozen_later", int'(frozen), 1);

        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
